serial_pair_tx: RTL and testbench

//   Parallel-to-serial transmitter for the two-stream serial interface (x, y; MSB first, one bit/clk)

---
 rtl/serial_pair_tx.sv | 136 +++++++++++++
 tb/tb_serial_pair_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_pair_tx.sv
// serial_pair_tx: two-stream (x/y) parallel-to-serial transmitter, MSB first,
// with frame_start/frame_end strobes and a programmable idle gap between frames.
// Optional feature macro: SPTX_PARITY_EN appends one even-parity bit per stream
// after bit 0 and adds the parity_slot output.
module serial_pair_tx #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             x,
  output logic             y,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
`ifdef SPTX_PARITY_EN
  output logic             parity_slot,
`endif
  output logic             busy
);

`ifdef SPTX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;      // frame cycles remaining after the one on x/y
  logic [GW-1:0]    gap_cnt;
  logic             accept;
`ifdef SPTX_PARITY_EN
  logic             par_a, par_b;
`endif

  // load_ready is a flop that is only high in IDLE, so this is the handshake
  assign accept = load_valid & load_ready;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = SHIFT;
      SHIFT: if (cnt == '0) state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // datapath and registered outputs; x/y carry one bit ahead of the shifters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_a        <= '0;
      sh_b        <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      x           <= 1'b0;
      y           <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b0;
`ifdef SPTX_PARITY_EN
      par_a       <= 1'b0;
      par_b       <= 1'b0;
      parity_slot <= 1'b0;
`endif
    end else begin
      busy       <= (state_n != IDLE);
      load_ready <= (state_n == IDLE);
      gap_cnt    <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      case (state)
        IDLE: begin
          if (accept) begin
            x           <= a_word[WIDTH-1];
            y           <= b_word[WIDTH-1];
            sh_a        <= {a_word[WIDTH-2:0], 1'b0};
            sh_b        <= {b_word[WIDTH-2:0], 1'b0};
            cnt         <= CW'(FL - 1);
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
`ifdef SPTX_PARITY_EN
            par_a       <= ^a_word;
            par_b       <= ^b_word;
`endif
          end
        end
        SHIFT: begin
          frame_start <= 1'b0;
          if (cnt == '0) begin
            x         <= 1'b0;
            y         <= 1'b0;
            bit_valid <= 1'b0;
            frame_end <= 1'b0;
`ifdef SPTX_PARITY_EN
            parity_slot <= 1'b0;
`endif
          end else begin
            cnt       <= cnt - CW'(1);
            sh_a      <= sh_a << 1;
            sh_b      <= sh_b << 1;
            frame_end <= (cnt == CW'(1));
`ifdef SPTX_PARITY_EN
            // last remaining cycle is the parity slot
            x           <= (cnt == CW'(1)) ? par_a : sh_a[WIDTH-1];
            y           <= (cnt == CW'(1)) ? par_b : sh_b[WIDTH-1];
            parity_slot <= (cnt == CW'(1));
`else
            x           <= sh_a[WIDTH-1];
            y           <= sh_b[WIDTH-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pair_tx.sv
// Directed, table-driven bench for serial_pair_tx (WIDTH=16, GAP_CYCLES=1).
module tb_serial_pair_tx;
  localparam int W = 16;
  localparam int G = 1;
`ifdef SPTX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         load_ready, x, y, bit_valid, frame_start, frame_end, busy;
  logic         parity_slot;

  serial_pair_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .a_word(a_word), .b_word(b_word), .x(x), .y(y), .bit_valid(bit_valid),
    .frame_start(frame_start), .frame_end(frame_end),
`ifdef SPTX_PARITY_EN
    .parity_slot(parity_slot),
`endif
    .busy(busy)
  );
`ifndef SPTX_PARITY_EN
  assign parity_slot = 1'b0;
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b, ex, ey;
    logic         px, py;
    bit           mid;
  } vec_t;
  vec_t tv[5];

  // one full frame plus the gap and return to idle, checked cycle by cycle
  task automatic send_frame(input vec_t v);
    int  n;
    logic ebx, eby;
    n = 0;
    while (!load_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_wait", {31'd0, load_ready}, 32'd1);
    a_word = v.a; b_word = v.b; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i < W) begin ebx = v.ex[W-1-i]; eby = v.ey[W-1-i]; end
      else       begin ebx = v.px;        eby = v.py;        end
      chk($sformatf("frame a=%h bit %0d {x,y,bv,fs,fe,busy,ps}", v.a, i),
          {25'd0, x, y, bit_valid, frame_start, frame_end, busy, parity_slot},
          {25'd0, ebx, eby, 1'b1, (i == 0), (i == FL-1), 1'b1, (i == W)});
      if (v.mid && i == 2) begin a_word = '1; b_word = '1; end
      @(posedge clk); #1;
    end
    chk("gap {x,y,bv,fs,fe,ps,busy,ready}",
        {24'd0, x, y, bit_valid, frame_start, frame_end, parity_slot, busy, load_ready},
        32'b0000_0010);
    @(posedge clk); #1;
    chk("idle {bv,busy,ready}", {29'd0, bit_valid, busy, load_ready}, 32'b001);
  endtask

  initial begin
    int   acc[$];
    int   gapc;
    logic pre;

    tv[0] = '{16'h3BC7, 16'h3BF8, 16'b0011101111000111, 16'b0011101111111000, 1'b0, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0000, 16'b1111111111111111, 16'b0000000000000000, 1'b0, 1'b0, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 16'b1000000000000000, 16'b0000000000000001, 1'b1, 1'b1, 1'b0};
    tv[3] = '{16'h1234, 16'hFEDC, 16'b0001001000110100, 16'b1111111011011100, 1'b1, 1'b0, 1'b0};
    tv[4] = '{16'h3BC7, 16'h3BF8, 16'b0011101111000111, 16'b0011101111111000, 1'b0, 1'b0, 1'b1};

    // reset: outputs low, load_valid ignored, ready one edge after release
    load_valid = 1'b1; a_word = 16'hAAAA; b_word = 16'h5555;
    #3;
    chk("reset outputs", {24'd0, x, y, bit_valid, frame_start, frame_end, busy, load_ready, parity_slot}, 32'd0);
    #7 rst = 1'b1; load_valid = 1'b0;
    #2;
    chk("ready before first edge", {31'd0, load_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready after first edge {ready,busy,bv}", {29'd0, load_ready, busy, bit_valid}, 32'b100);

    for (int k = 0; k < 4; k++) send_frame(tv[k]);

    // held load_valid: accept spacing and gap length
    a_word = tv[0].a; b_word = tv[0].b; load_valid = 1'b1;
    pre = load_ready & load_valid; gapc = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (pre) acc.push_back(c);
      if (acc.size() == 2) load_valid = 1'b0;
      if (acc.size() == 1 && !bit_valid && busy) gapc++;
      pre = load_ready & load_valid;
    end
    chk("accept count", acc.size(), 2);
    if (acc.size() == 2) chk("accept spacing", acc[1] - acc[0], FL + G + 1);
    chk("gap cycles", gapc, G);

    // inputs changed mid-frame are ignored
    send_frame(tv[4]);

    // async reset at bit 8, then a clean frame
    while (!load_ready) begin @(posedge clk); #1; end
    a_word = tv[1].a; b_word = tv[1].b; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    chk("bit8 before reset {x,y,bv,busy}", {28'd0, x, y, bit_valid, busy}, 32'b1011);
    rst = 1'b0;
    #1;
    chk("async reset drop", {25'd0, x, y, bit_valid, busy, load_ready, frame_start, frame_end}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame(tv[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
